// File: rtl/easyaxi_slv_rd.sv
// rtl/easyaxi_slv_rd.sv - EasyAXI read-channel slave returning address-pattern data
//
// Purpose: accepts AR requests into an in-order outstanding queue and returns
// each burst on R, one beat per handshake, with FIXED/INCR/WRAP addressing.
// Read data is the beat address itself; bad requests still return len+1
// beats carrying SLVERR or DECERR.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   axi_slv_ar*                AR channel in (valid/ready/id/addr/len/size/burst)
//   axi_slv_r*                 R channel out (valid/ready/id/data/resp/last)

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_rd #(
    parameter int                       OST_DEPTH     = 8,
    parameter int                       MAX_BURST_LEN = 8,
    parameter logic [`AXI_ADDR_W-1:0]   ADDR_LIMIT    = 'h1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        axi_slv_arvalid,
    output logic                        axi_slv_arready,
    input  logic [`AXI_ID_W-1:0]        axi_slv_arid,
    input  logic [`AXI_ADDR_W-1:0]      axi_slv_araddr,
    input  logic [`AXI_LEN_W-1:0]       axi_slv_arlen,
    input  logic [`AXI_SIZE_W-1:0]      axi_slv_arsize,
    input  logic [`AXI_BURST_W-1:0]     axi_slv_arburst,
    output logic                        axi_slv_rvalid,
    input  logic                        axi_slv_rready,
    output logic [`AXI_ID_W-1:0]        axi_slv_rid,
    output logic [`AXI_DATA_W-1:0]      axi_slv_rdata,
    output logic [`AXI_RESP_W-1:0]      axi_slv_rresp,
    output logic                        axi_slv_rlast
);

    localparam int AW        = `AXI_ADDR_W;
    localparam int LW        = `AXI_LEN_W;
    localparam int OST_CNT_W = $clog2(OST_DEPTH);

    localparam logic [`AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [`AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [`AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;
    localparam logic [`AXI_BURST_W-1:0] BURST_RSVD  = 2'b11;

    localparam logic [`AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [`AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;
    localparam logic [`AXI_RESP_W-1:0]  RESP_DECERR = 2'b11;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [OST_CNT_W:0] DEPTH_C = (OST_CNT_W+1)'(OST_DEPTH);

    typedef struct packed {
        logic [`AXI_ID_W-1:0]    id;
        logic [AW-1:0]           addr;
        logic [LW-1:0]           len;
        logic [`AXI_SIZE_W-1:0]  size;
        logic [`AXI_BURST_W-1:0] burst;
        logic [`AXI_RESP_W-1:0]  resp;
    } ent_t;

    // Outstanding queue
    ent_t                   r_q [OST_DEPTH];
    logic [OST_CNT_W-1:0]   r_wptr;
    logic [OST_CNT_W-1:0]   r_rptr;
    logic [OST_CNT_W:0]     r_cnt;
    logic                   r_arready;

    // Current burst
    logic [0:0]                 r_state;
    logic [AW-1:0]              r_addr;
    logic [LW-1:0]              r_beat;
    logic [`AXI_ID_W-1:0]       r_id;
    logic [LW-1:0]              r_len;
    logic [`AXI_SIZE_W-1:0]     r_size;
    logic [`AXI_BURST_W-1:0]    r_burst;
    logic [`AXI_RESP_W-1:0]     r_resp;

    ent_t                   w_new;
    ent_t                   w_head;
    ent_t                   w_next_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_rlast;
    logic                   w_rvalid;
    logic [OST_CNT_W:0]     w_cnt_nxt;
    logic [LW:0]            w_len_p1;
    logic                   w_wrap_len_ok;

    // Beat address after the current one. For WRAP bursts with an illegal
    // length the total is not a power of two; those bursts carry SLVERR and
    // the address pattern is only a best effort.
    function automatic logic [AW-1:0] f_next_addr(
        input logic [AW-1:0]           addr,
        input logic [LW-1:0]           len,
        input logic [`AXI_SIZE_W-1:0]  size,
        input logic [`AXI_BURST_W-1:0] burst
    );
        logic [AW-1:0] bytes;
        logic [AW-1:0] total;
        logic [AW-1:0] base;
        bytes = AW'(1) << size;
        total = AW'({1'b0, len} + {{LW{1'b0}}, 1'b1}) * bytes;
        base  = addr & ~(total - AW'(1));
        case (burst)
            BURST_INCR: f_next_addr = (addr & ~(bytes - AW'(1))) + bytes;
            BURST_WRAP: f_next_addr = base + ((addr + bytes - base) & (total - AW'(1)));
            default:    f_next_addr = addr;
        endcase
    endfunction

    assign w_rvalid    = (r_state == S_BURST);
    assign w_rlast     = w_rvalid && (r_beat == r_len);
    assign w_push      = axi_slv_arvalid && r_arready;
    assign w_pop       = w_rvalid && axi_slv_rready && w_rlast;
    assign w_cnt_nxt   = r_cnt + {{OST_CNT_W{1'b0}}, w_push} - {{OST_CNT_W{1'b0}}, w_pop};
    assign w_head      = r_q[r_rptr];
    assign w_next_head = r_q[r_rptr + OST_CNT_W'(1)];

    assign w_len_p1      = {1'b0, axi_slv_arlen} + {{LW{1'b0}}, 1'b1};
    assign w_wrap_len_ok = (axi_slv_arlen == LW'(1)) || (axi_slv_arlen == LW'(3)) ||
                           (axi_slv_arlen == LW'(7)) || (axi_slv_arlen == LW'(15));

    always_comb begin
        w_new.id    = axi_slv_arid;
        w_new.addr  = axi_slv_araddr;
        w_new.len   = axi_slv_arlen;
        w_new.size  = axi_slv_arsize;
        w_new.burst = axi_slv_arburst;
        w_new.resp  = RESP_OKAY;
        if (axi_slv_araddr >= ADDR_LIMIT) begin
            w_new.resp = RESP_DECERR;
        end else if ((32'(w_len_p1) > 32'(MAX_BURST_LEN)) ||
                     ((axi_slv_arburst == BURST_WRAP) && !w_wrap_len_ok) ||
                     (axi_slv_arburst == BURST_RSVD)) begin
            w_new.resp = RESP_SLVERR;
        end
    end

    // Payload storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wptr] <= w_new;
        end
    end

    // arready is registered from next-cycle occupancy, so a pop while full
    // reopens the queue one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_arready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + OST_CNT_W'(1);
            if (w_pop)  r_rptr <= r_rptr + OST_CNT_W'(1);
            r_cnt     <= w_cnt_nxt;
            r_arready <= (w_cnt_nxt < DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_beat  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= BURST_FIXED;
            r_resp  <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cnt != '0) begin
                        r_state <= S_BURST;
                        r_addr  <= w_head.addr;
                        r_beat  <= '0;
                        r_id    <= w_head.id;
                        r_len   <= w_head.len;
                        r_size  <= w_head.size;
                        r_burst <= w_head.burst;
                        r_resp  <= w_head.resp;
                    end
                end
                default: begin
                    if (axi_slv_rready) begin
                        if (w_rlast) begin
                            // Chain into the next burst without a bubble. With
                            // only the current entry queued, a same-cycle push
                            // is forwarded straight from the AR inputs.
                            if (r_cnt > (OST_CNT_W+1)'(1)) begin
                                r_addr  <= w_next_head.addr;
                                r_beat  <= '0;
                                r_id    <= w_next_head.id;
                                r_len   <= w_next_head.len;
                                r_size  <= w_next_head.size;
                                r_burst <= w_next_head.burst;
                                r_resp  <= w_next_head.resp;
                            end else if (w_push) begin
                                r_addr  <= w_new.addr;
                                r_beat  <= '0;
                                r_id    <= w_new.id;
                                r_len   <= w_new.len;
                                r_size  <= w_new.size;
                                r_burst <= w_new.burst;
                                r_resp  <= w_new.resp;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_addr <= f_next_addr(r_addr, r_len, r_size, r_burst);
                            r_beat <= r_beat + LW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign axi_slv_arready = r_arready;
    assign axi_slv_rvalid  = w_rvalid;
    assign axi_slv_rlast   = w_rlast;
    assign axi_slv_rid     = r_id;
    assign axi_slv_rdata   = `AXI_DATA_W'(r_addr);
    assign axi_slv_rresp   = r_resp;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// tb/tb_easyaxi_slv_rd.sv - directed self-checking bench for easyaxi_slv_rd

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_slv_rd;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     arvalid;
    logic                     arready;
    logic [`AXI_ID_W-1:0]     arid;
    logic [`AXI_ADDR_W-1:0]   araddr;
    logic [`AXI_LEN_W-1:0]    arlen;
    logic [`AXI_SIZE_W-1:0]   arsize;
    logic [`AXI_BURST_W-1:0]  arburst;
    logic                     rvalid;
    logic                     rready;
    logic [`AXI_ID_W-1:0]     rid;
    logic [`AXI_DATA_W-1:0]   rdata;
    logic [`AXI_RESP_W-1:0]   rresp;
    logic                     rlast;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_data [64];
    logic [3:0]  got_id   [64];
    logic [1:0]  got_resp [64];
    logic        got_last [64];
    int          got_n;

    always #5 clk = ~clk;

    easyaxi_slv_rd dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arsize  (arsize),
        .axi_slv_arburst (arburst),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        while (!arready && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (arready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_accept id=%0d: arready=%b required 1", id, arready);
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic collect(input int n);
        int budget = 0;
        got_n  = 0;
        rready = 1'b1;
        while (got_n < n && budget < 500) begin
            if (rvalid) begin
                got_data[got_n] = rdata;
                got_id[got_n]   = rid;
                got_resp[got_n] = rresp;
                got_last[got_n] = rlast;
                got_n++;
            end
            tick();
            budget++;
        end
        n_checks++;
        if (got_n != n) begin
            n_fail++;
            $display("FAIL collect_beats: got %0d beats, required %0d", got_n, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({arready, rvalid, rlast} !== 3'b100 || rid !== 4'd0 || rdata !== 32'd0 || rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b required 1 0 0 0 0 00",
                     arready, rvalid, rlast, rid, rdata, rresp);
        end
    endtask

    task automatic test_incr();
        rready = 1'b1;
        send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_latency_n1: rvalid=%b required 0", rvalid);
        end
        tick();
        n_checks++;
        if (rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL incr_latency_n2: rvalid=%b required 1", rvalid);
        end
        collect(4);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_data[k] !== 32'h10 + 32'(4 * k) || got_id[k] !== 4'd1 || got_resp[k] !== 2'b00 ||
                got_last[k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL incr_beat%0d: data=%h id=%0d resp=%b last=%b required %h 1 00 %b",
                         k, got_data[k], got_id[k], got_resp[k], got_last[k], 32'h10 + 32'(4 * k), k == 3);
            end
        end
    endtask

    task automatic test_wrap_fixed();
        logic [31:0] exp [3][8];
        logic [31:0] st  [3];
        logic [7:0]  ln  [3];
        logic [1:0]  bt  [3];
        exp[0] = '{32'h34, 32'h38, 32'h3C, 32'h30, 0, 0, 0, 0};
        exp[1] = '{32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
        exp[2] = '{32'h30, 32'h30, 32'h30, 32'h30, 0, 0, 0, 0};
        st = '{32'h34, 32'h38, 32'h30};
        ln = '{8'd3, 8'd7, 8'd3};
        bt = '{2'b10, 2'b10, 2'b00};
        rready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            send_ar(4'(j + 2), st[j], ln[j], 3'd2, bt[j]);
            collect(int'(ln[j]) + 1);
            for (int k = 0; k <= int'(ln[j]); k++) begin
                n_checks++;
                if (got_data[k] !== exp[j][k] || got_resp[k] !== 2'b00 || got_last[k] !== (k == int'(ln[j]))) begin
                    n_fail++;
                    $display("FAIL wrapfix%0d_beat%0d: data=%h resp=%b last=%b required %h 00 %b",
                             j, k, got_data[k], got_resp[k], got_last[k], exp[j][k], k == int'(ln[j]));
                end
            end
        end
    endtask

    task automatic test_outstanding();
        rready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_ar(4'(i), 32'h80 + 32'(16 * i), 8'd0, 3'd2, 2'b01);
        end
        n_checks++;
        if (arready !== 1'b0) begin
            n_fail++;
            $display("FAIL ost_full: arready=%b required 0", arready);
        end
        arvalid = 1'b1; arid = 4'd8; araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        tick(); tick(); tick();
        n_checks++;
        if (arready !== 1'b0 || rvalid !== 1'b1 || rid !== 4'd0) begin
            n_fail++;
            $display("FAIL ost_stall: arready=%b rvalid=%b rid=%0d required 0 1 0", arready, rvalid, rid);
        end
        rready = 1'b1;
        tick();
        n_checks++;
        if (arready !== 1'b1 || rvalid !== 1'b1 || rid !== 4'd1) begin
            n_fail++;
            $display("FAIL ost_reopen: arready=%b rvalid=%b rid=%0d required 1 1 1", arready, rvalid, rid);
        end
        tick();
        arvalid = 1'b0;
        collect(7);
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (got_id[k] !== 4'(k + 2) || got_last[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL ost_order%0d: rid=%0d last=%b required %0d 1", k, got_id[k], got_last[k], k + 2);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pat;
        logic [31:0] h_data;
        logic [3:0]  h_id;
        logic        h_last;
        logic        stalled;
        int          hs;
        int          stall_seen;
        pat = 32'b1011_0010_1110_0101_1001_1100_0110_1011;
        stalled = 1'b0; hs = 0; stall_seen = 0;
        h_data = '0; h_id = '0; h_last = 1'b0;
        rready = 1'b0;
        send_ar(4'd9, 32'h40, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 100 && hs < 8; i++) begin
            rready = pat[i % 32];
            if (rvalid) begin
                if (stalled) begin
                    stall_seen++;
                    n_checks++;
                    if (rdata !== h_data || rid !== h_id || rlast !== h_last || rresp !== 2'b00) begin
                        n_fail++;
                        $display("FAIL stall_hold cyc%0d: data=%h id=%0d last=%b required %h %0d %b",
                                 i, rdata, rid, rlast, h_data, h_id, h_last);
                    end
                end
                if (rready) begin
                    n_checks++;
                    if (rdata !== 32'h40 + 32'(4 * hs) || rlast !== (hs == 7)) begin
                        n_fail++;
                        $display("FAIL stall_beat%0d: data=%h last=%b required %h %b",
                                 hs, rdata, rlast, 32'h40 + 32'(4 * hs), hs == 7);
                    end
                    hs++;
                    stalled = 1'b0;
                end else begin
                    h_data = rdata; h_id = rid; h_last = rlast;
                    stalled = 1'b1;
                end
            end
            tick();
        end
        n_checks++;
        if (hs != 8 || rvalid !== 1'b0 || stall_seen == 0) begin
            n_fail++;
            $display("FAIL stall_count: handshakes=%0d rvalid=%b stalls=%0d required 8 0 >0", hs, rvalid, stall_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  eid [4];
        logic [31:0] edat [4];
        eid  = '{4'd5, 4'd5, 4'd6, 4'd6};
        edat = '{32'h300, 32'h304, 32'h400, 32'h404};
        rready = 1'b1;
        send_ar(4'd5, 32'h300, 8'd1, 3'd2, 2'b01);
        send_ar(4'd6, 32'h400, 8'd1, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rid !== eid[k] || rdata !== edat[k] || rlast !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: rvalid=%b rid=%0d data=%h last=%b required 1 %0d %h %b",
                         k, rvalid, rid, rdata, rlast, eid[k], edat[k], k % 2 == 1);
            end
            tick();
        end
        send_ar(4'd7, 32'h500, 8'd0, 3'd2, 2'b01);
        tick();
        arvalid = 1'b1; arid = 4'd8; araddr = 32'h600; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        n_checks++;
        if (rvalid !== 1'b1 || rid !== 4'd7 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_fwd_a: rvalid=%b rid=%0d arready=%b required 1 7 1", rvalid, rid, arready);
        end
        tick();
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rid !== 4'd8 || rdata !== 32'h600 || rlast !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_fwd_b: rvalid=%b rid=%0d data=%h last=%b required 1 8 600 1", rvalid, rid, rdata, rlast);
        end
        tick();
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_errors();
        rready = 1'b1;
        send_ar(4'd9, 32'h20, 8'd8, 3'd2, 2'b01);
        collect(9);
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (got_resp[k] !== 2'b10 || got_last[k] !== (k == 8)) begin
                n_fail++;
                $display("FAIL slverr_len_beat%0d: resp=%b last=%b required 10 %b", k, got_resp[k], got_last[k], k == 8);
            end
        end
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL slverr_len_extra: rvalid=%b required 0", rvalid);
        end
        send_ar(4'd10, 32'h1000, 8'd1, 3'd2, 2'b01);
        collect(2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_resp[k] !== 2'b11 || got_id[k] !== 4'd10 || got_last[k] !== (k == 1)) begin
                n_fail++;
                $display("FAIL decerr_beat%0d: resp=%b id=%0d last=%b required 11 10 %b",
                         k, got_resp[k], got_id[k], got_last[k], k == 1);
            end
        end
        send_ar(4'd11, 32'h40, 8'd2, 3'd2, 2'b10);
        collect(3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (got_resp[k] !== 2'b10 || got_last[k] !== (k == 2)) begin
                n_fail++;
                $display("FAIL slverr_wrap_beat%0d: resp=%b last=%b required 10 %b", k, got_resp[k], got_last[k], k == 2);
            end
        end
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL slverr_wrap_extra: rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_reset_mid_burst();
        rready = 1'b1;
        send_ar(4'd3, 32'h100, 8'd3, 3'd2, 2'b01);
        tick();
        tick();
        tick();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h108) begin
            n_fail++;
            $display("FAIL rst_mid_pre: rvalid=%b data=%h required 1 108", rvalid, rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: rvalid=%b rlast=%b required 0 0", rvalid, rlast);
        end
        tick();
        #3 rst_n = 1'b1;
        tick();
        n_checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        send_ar(4'd4, 32'h200, 8'd1, 3'd2, 2'b01);
        collect(2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_data[k] !== 32'h200 + 32'(4 * k) || got_id[k] !== 4'd4 || got_last[k] !== (k == 1)) begin
                n_fail++;
                $display("FAIL rst_mid_new_beat%0d: data=%h id=%0d last=%b required %h 4 %b",
                         k, got_data[k], got_id[k], got_last[k], 32'h200 + 32'(4 * k), k == 1);
            end
        end
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_extra: rvalid=%b required 0", rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_outstanding();
        test_stall();
        test_back_to_back();
        test_errors();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
